// File: rtl/ps4_pkg.sv
// Shared types and helpers for the ps4 requester front end.
package ps4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        HOLD = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int         NUM_CH   = 4;
    localparam logic [3:0] GNT_NONE = 4'b0000;

    typedef struct packed {
        logic       legal;
        logic [1:0] idx;
    } sel_t;

    // Index of a one-hot grant; legal only when exactly one bit is set.
    function automatic sel_t onehot_idx(input logic [3:0] v);
        sel_t r;
        r.legal = 1'b0;
        r.idx   = 2'd0;
        case (v)
            4'b0001: begin r.legal = 1'b1; r.idx = 2'd0; end
            4'b0010: begin r.legal = 1'b1; r.idx = 2'd1; end
            4'b0100: begin r.legal = 1'b1; r.idx = 2'd2; end
            4'b1000: begin r.legal = 1'b1; r.idx = 2'd3; end
            default: begin r.legal = 1'b0; r.idx = 2'd0; end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps4_pend_cnt.sv
// Per-channel saturating pending-job counter with sticky overflow flag.
module ps4_pend_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             ovf
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_r;
    logic             ovf_r;

    // Counter update; a push and a completion in the same cycle cancel out.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else if (push && !dec) begin
            if (count_r == CNT_MAX) begin
                ovf_r <= 1'b1;
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end else if (dec && !push) begin
            count_r <= count_r - CNT_W'(1);
        end
    end

    assign count   = count_r;
    assign nonzero = (count_r != '0);
    assign ovf     = ovf_r;

endmodule

// File: rtl/ps4_requester.sv
// Requester front end: queues jobs per channel, arbitrates one job at a time
// and holds the granted channel for a fixed window while checking the grant.
module ps4_requester
    import ps4_pkg::*;
#(
    parameter int CNT_W    = 3,
    parameter int HOLD_CYC = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] job_push,
    input  logic [3:0] gnt,
    output logic [3:0] req,
    output logic       en,
    output logic [1:0] owner,
    output logic       active,
    output logic       done,
    output logic       ovf,
    output logic       err
);
    state_t     state_r, state_nx;
    logic [1:0] owner_r, owner_nx;
    logic [7:0] hold_r, hold_nx;
    logic       active_r, active_nx;
    logic       done_r, done_nx;
    logic       err_r, err_nx;

    logic [3:0] req_s, dec_s, pmask_s, own_oh_s, cnt_ovf_s;
    logic       en_s;
    sel_t       gsel_s;
    logic [CNT_W-1:0] pend_s [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ps4_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clock   (clock),
            .reset_n (reset_n),
            .push    (job_push[i]),
            .dec     (dec_s[i] && (pend_s[i] != '0)),
            .count   (pend_s[i]),
            .nonzero (pmask_s[i]),
            .ovf     (cnt_ovf_s[i])
        );
    end

    assign own_oh_s = 4'b0001 << owner_r;
    assign gsel_s   = onehot_idx(gnt);

    // Next-state decode; req/en depend only on state and registered values.
    always_comb begin
        state_nx = state_r;
        owner_nx = owner_r;
        hold_nx  = hold_r;
        done_nx  = 1'b0;
        err_nx   = err_r;
        dec_s    = 4'b0000;
        req_s    = 4'b0000;
        en_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (pmask_s != 4'b0000) begin
                    state_nx = ARB;
                end else begin
                    state_nx = IDLE;
                end
            end
            ARB: begin
                en_s  = 1'b1;
                req_s = pmask_s;
                if (gsel_s.legal && ((gnt & pmask_s) != GNT_NONE)) begin
                    owner_nx = gsel_s.idx;
                    hold_nx  = 8'(HOLD_CYC - 1);
                    state_nx = HOLD;
                end else begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            HOLD: begin
                en_s  = 1'b1;
                req_s = own_oh_s;
                if (gnt != own_oh_s) begin
                    err_nx   = 1'b1;
                    state_nx = GAP;
                end else if (hold_r == 8'd0) begin
                    done_nx  = 1'b1;
                    dec_s    = own_oh_s;
                    state_nx = GAP;
                end else begin
                    hold_nx  = hold_r - 8'd1;
                    state_nx = HOLD;
                end
            end
            GAP: begin
                if (pmask_s != 4'b0000) begin
                    state_nx = ARB;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        active_nx = (state_nx == HOLD);
    end

    // State and registered-output update.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            owner_r  <= 2'd0;
            hold_r   <= 8'd0;
            active_r <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_nx;
            owner_r  <= owner_nx;
            hold_r   <= hold_nx;
            active_r <= active_nx;
            done_r   <= done_nx;
            err_r    <= err_nx;
        end
    end

    assign req    = req_s;
    assign en     = en_s;
    assign owner  = owner_r;
    assign active = active_r;
    assign done   = done_r;
    assign err    = err_r;
    assign ovf    = |cnt_ovf_s;

endmodule

// File: tb/tb_ps4_requester.sv
// Bench for ps4_requester: an ideal (lowest-index) selector plus forced faults,
// checked every cycle against a job-level reference model.
module tb_ps4_requester;
    localparam int CNT_W    = 3;
    localparam int HOLD_CYC = 4;
    localparam int MAXP     = (1 << CNT_W) - 1;
    localparam int M_IDLE = 0, M_ARB = 1, M_HOLD = 2, M_GAP = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] job_push = 4'b0000;
    logic [3:0] gnt = 4'b0000;
    logic [3:0] req;
    logic       en;
    logic [1:0] owner;
    logic       active, done, ovf, err;

    ps4_requester #(.CNT_W(CNT_W), .HOLD_CYC(HOLD_CYC)) dut (
        .clock(clock), .reset_n(reset_n), .job_push(job_push), .gnt(gnt),
        .req(req), .en(en), .owner(owner), .active(active), .done(done),
        .ovf(ovf), .err(err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int dut_dones = 0;

    int m_pend [4];
    int m_phase = M_IDLE;
    int m_owner = 0;
    int m_left = 0;
    bit m_done = 1'b0, m_err = 1'b0, m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_mask();
        logic [3:0] m = 4'b0000;
        for (int i = 0; i < 4; i++) if (m_pend[i] > 0) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [3:0] m_req();
        if (m_phase == M_ARB) return m_mask();
        if (m_phase == M_HOLD) return 4'b0001 << m_owner;
        return 4'b0000;
    endfunction

    task automatic model_step(input logic [3:0] p, input logic [3:0] g, input logic rn);
        int dec_ch;
        bit any;
        logic [3:0] oh;
        if (!rn) begin
            for (int i = 0; i < 4; i++) m_pend[i] = 0;
            m_phase = M_IDLE; m_owner = 0; m_left = 0;
            m_done = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
            return;
        end
        dec_ch = -1;
        any = (m_mask() != 4'b0000);
        m_done = 1'b0;
        oh = 4'b0001 << m_owner;
        case (m_phase)
            M_IDLE: if (any) m_phase = M_ARB;
            M_ARB: begin
                if ($countones(g) == 1 && (g & m_mask()) != 4'b0000) begin
                    for (int i = 0; i < 4; i++) if (g[i]) m_owner = i;
                    m_left = HOLD_CYC;
                    m_phase = M_HOLD;
                end else begin
                    m_err = 1'b1;
                    m_phase = M_IDLE;
                end
            end
            M_HOLD: begin
                if (g != oh) begin
                    m_err = 1'b1;
                    m_phase = M_GAP;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_done = 1'b1;
                        dec_ch = m_owner;
                        m_phase = M_GAP;
                    end
                end
            end
            default: m_phase = any ? M_ARB : M_IDLE;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (p[i] && dec_ch == i) begin
                m_pend[i] = m_pend[i];
            end else if (p[i]) begin
                if (m_pend[i] == MAXP) m_ovf = 1'b1;
                else m_pend[i]++;
            end else if (dec_ch == i) begin
                m_pend[i]--;
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare #1 later.
    task automatic cyc(input logic [3:0] p, input bit frc, input logic [3:0] fg);
        logic [3:0] r, g;
        r = m_req();
        g = frc ? fg : (r & (~r + 4'd1));
        job_push = p;
        gnt = g;
        @(posedge clock);
        model_step(p, g, reset_n);
        #1;
        if (done === 1'b1) dut_dones++;
        chk("req", {4'b0000, req}, {4'b0000, m_req()});
        chk("en", {7'b0, en}, {7'b0, (m_phase == M_ARB || m_phase == M_HOLD)});
        chk("owner", {6'b0, owner}, 8'(m_owner));
        chk("active", {7'b0, active}, {7'b0, (m_phase == M_HOLD)});
        chk("done", {7'b0, done}, {7'b0, m_done});
        chk("ovf", {7'b0, ovf}, {7'b0, m_ovf});
        chk("err", {7'b0, err}, {7'b0, m_err});
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) cyc(4'b0000, 1'b0, 4'b0000);
    endtask

    task automatic wait_phase(input string tag, input int ph, input int left);
        int k;
        k = 0;
        while (!(m_phase == ph && (left < 0 || m_left == left)) && k < 40) begin
            cyc(4'b0000, 1'b0, 4'b0000);
            k++;
        end
        chk(tag, {7'b0, (m_phase == ph)}, 8'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(4'b1111, 1'b0, 4'b0000);
        cyc(4'b1111, 1'b0, 4'b0000);
        reset_n = 1'b1;
    endtask

    initial begin
        int act_cnt;
        logic [3:0] p;

        // Reset with pushes asserted: everything stays clear.
        do_reset();
        chk("rst_req", {4'b0, req}, 8'h00);
        chk("rst_ovf", {7'b0, ovf}, 8'h00);
        idle_n(2);
        chk("rst_noarb", {7'b0, en}, 8'h00);

        // Single job on channel 1.
        dut_dones = 0;
        cyc(4'b0010, 1'b0, 4'b0000);
        cyc(4'b0000, 1'b0, 4'b0000);
        chk("ch1_req_lat2", {4'b0, req}, 8'h02);
        act_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(4'b0000, 1'b0, 4'b0000);
            if (active === 1'b1 && owner === 2'd1) act_cnt++;
        end
        chk("ch1_hold_len", 8'(act_cnt), 8'(HOLD_CYC));
        chk("ch1_done_cnt", 8'(dut_dones), 8'd1);
        chk("ch1_back_idle", {3'b0, en, req}, 8'h00);

        // Channel 3 arrives during channel 0's hold and waits its turn.
        cyc(4'b0001, 1'b0, 4'b0000);
        wait_phase("ch0_hold", M_HOLD, -1);
        cyc(4'b1000, 1'b0, 4'b0000);
        chk("ch0_not_preempt", {4'b0, req}, 8'h01);
        wait_phase("ch3_arb", M_ARB, -1);
        chk("ch3_req", {4'b0, req}, 8'h08);
        cyc(4'b0000, 1'b0, 4'b0000);
        chk("ch3_owner", {6'b0, owner}, 8'd3);
        idle_n(10);

        // Saturation on channel 2: one job drains during the pushes, seven remain.
        do_reset();
        dut_dones = 0;
        for (int k = 0; k < 9; k++) cyc(4'b0100, 1'b0, 4'b0000);
        chk("sat_ovf", {7'b0, ovf}, 8'd1);
        idle_n(60);
        chk("sat_dones", 8'(dut_dones), 8'd8);

        // Illegal grants in ARB and in HOLD.
        do_reset();
        cyc(4'b0011, 1'b0, 4'b0000);
        wait_phase("ill_arb", M_ARB, -1);
        cyc(4'b0000, 1'b1, 4'b0011);
        chk("ill_arb_err", {7'b0, err}, 8'd1);
        chk("ill_arb_idle", {7'b0, en}, 8'd0);
        wait_phase("ill_arb2", M_ARB, -1);
        cyc(4'b0000, 1'b1, 4'b0010);
        chk("ill_owner1", {6'b0, owner}, 8'd1);
        cyc(4'b0000, 1'b1, 4'b0100);
        chk("ill_hold_gap", {6'b0, active, done}, 8'd0);
        idle_n(30);

        // Push on channel 0 in its completion cycle: job count preserved.
        do_reset();
        cyc(4'b0001, 1'b0, 4'b0000);
        wait_phase("cmp_last", M_HOLD, 1);
        cyc(4'b0001, 1'b0, 4'b0000);
        chk("cmp_done", {7'b0, done}, 8'd1);
        cyc(4'b0000, 1'b0, 4'b0000);
        chk("cmp_rearb", {4'b0, req}, 8'h01);
        idle_n(10);

        // Reset in the middle of a hold aborts the job and clears the queue.
        cyc(4'b0100, 1'b0, 4'b0000);
        wait_phase("mid_hold", M_HOLD, -1);
        reset_n = 1'b0;
        cyc(4'b0000, 1'b0, 4'b0000);
        chk("mid_rst_act", {3'b0, active, req}, 8'h00);
        reset_n = 1'b1;
        idle_n(4);
        chk("mid_rst_empty", {7'b0, en}, 8'd0);

        // Randomized traffic with occasional bad grants and resets.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            p = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            reset_n = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            cyc(p, ($urandom_range(0, 24) == 0), 4'($urandom_range(0, 15)));
        end
        reset_n = 1'b1;
        idle_n(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
